// File: rtl/rgbx_pack_ctrl.sv
// rgbx_pack_ctrl: strips alpha from 128b RGBX beats and packs dense 128b RGB.
// Optional RGBX_PACK_TKEEP_EN adds an O_m_tkeep byte-lane mask output.
module rgbx_pack_ctrl #(
  parameter logic [7:0] PAD_BYTE = 8'h00
) (
  input  logic         I_clk,
  input  logic         I_rstn,
  input  logic [127:0] I_s_tdata,
  input  logic         I_s_tvalid,
  output logic         O_s_tready,
  input  logic         I_s_tlast,
  input  logic         I_s_tuser,
  output logic [127:0] O_m_tdata,
  output logic         O_m_tvalid,
  input  logic         I_m_tready,
  output logic         O_m_tlast,
  output logic         O_m_tuser,
  output logic         O_unaligned
`ifdef RGBX_PACK_TKEEP_EN
  ,
  output logic [15:0]  O_m_tkeep
`endif
);

  typedef enum logic [2:0] {
    S0,
    S12,
    S8,
    S4,
    FLUSH
  } state_e;

  state_e        state_q, state_d;
  logic [95:0]   res_q, res_d;
  logic          flush8_q, flush8_d;
  logic          sof_q, sof_d;
  logic          unal_q, unal_d;

  logic [127:0]  mdata_q, mdata_d;
  logic          mvld_q, mvld_d;
  logic          mlast_q, mlast_d;
  logic          muser_q, muser_d;

  logic [95:0]   rgb;
  logic          out_free;
  logic          s_rdy;
  logic          s_acc;
  logic          sof_now;

  logic          emit;
  logic [127:0]  pkt_data;
  logic          pkt_last;
  logic          set_unal;

`ifdef RGBX_PACK_TKEEP_EN
  logic [15:0]   keep_q, keep_d;
  logic [15:0]   pkt_keep;
`endif

  assign rgb = {I_s_tdata[119:96], I_s_tdata[87:64],
                I_s_tdata[55:32],  I_s_tdata[23:0]};

  // Reset gating keeps ready low while held in reset.
  assign out_free = !mvld_q || I_m_tready;
  assign s_rdy    = out_free && (state_q != FLUSH) && I_rstn;
  assign s_acc    = I_s_tvalid && s_rdy;
  assign sof_now  = sof_q || (s_acc && I_s_tuser);

  // Packing sequencer: residue bookkeeping and candidate output beat.
  always_comb begin
    state_d  = state_q;
    res_d    = res_q;
    flush8_d = flush8_q;
    emit     = 1'b0;
    pkt_data = '0;
    pkt_last = 1'b0;
    set_unal = 1'b0;
`ifdef RGBX_PACK_TKEEP_EN
    pkt_keep = 16'hFFFF;
`endif
    if (s_acc) begin
      unique case (state_q)
        S0: begin
          if (I_s_tlast) begin
            emit     = 1'b1;
            pkt_data = {{4{PAD_BYTE}}, rgb};
            pkt_last = 1'b1;
            set_unal = 1'b1;
`ifdef RGBX_PACK_TKEEP_EN
            pkt_keep = 16'h0FFF;
`endif
          end else begin
            res_d   = rgb;
            state_d = S12;
          end
        end
        S12: begin
          emit     = 1'b1;
          pkt_data = {rgb[31:0], res_q};
          res_d    = {32'h0, rgb[95:32]};
          flush8_d = 1'b1;
          state_d  = I_s_tlast ? FLUSH : S8;
        end
        S8: begin
          emit     = 1'b1;
          pkt_data = {rgb[63:0], res_q[63:0]};
          res_d    = {64'h0, rgb[95:64]};
          flush8_d = 1'b0;
          state_d  = I_s_tlast ? FLUSH : S4;
        end
        S4: begin
          emit     = 1'b1;
          pkt_data = {rgb, res_q[31:0]};
          pkt_last = I_s_tlast;
          res_d    = '0;
          state_d  = S0;
        end
        default: begin
          state_d = S0;
        end
      endcase
    end else if (state_q == FLUSH && out_free) begin
      emit     = 1'b1;
      pkt_last = 1'b1;
      set_unal = 1'b1;
      res_d    = '0;
      state_d  = S0;
      if (flush8_q) begin
        pkt_data = {{8{PAD_BYTE}}, res_q[63:0]};
`ifdef RGBX_PACK_TKEEP_EN
        pkt_keep = 16'h00FF;
`endif
      end else begin
        pkt_data = {{12{PAD_BYTE}}, res_q[31:0]};
`ifdef RGBX_PACK_TKEEP_EN
        pkt_keep = 16'h000F;
`endif
      end
    end
  end

  // Output register: loads only when the downstream slot is free.
  always_comb begin
    mvld_d  = mvld_q;
    mdata_d = mdata_q;
    mlast_d = mlast_q;
    muser_d = muser_q;
`ifdef RGBX_PACK_TKEEP_EN
    keep_d  = keep_q;
`endif
    if (out_free) begin
      mvld_d  = emit;
      mdata_d = pkt_data;
      mlast_d = pkt_last;
      muser_d = emit && sof_now;
`ifdef RGBX_PACK_TKEEP_EN
      keep_d  = emit ? pkt_keep : 16'h0;
`endif
    end
    sof_d  = emit ? 1'b0 : sof_now;
    unal_d = unal_q || set_unal;
  end

  // State, residue and output registers.
  always_ff @(posedge I_clk or negedge I_rstn) begin
    if (!I_rstn) begin
      state_q  <= S0;
      res_q    <= '0;
      flush8_q <= 1'b0;
      sof_q    <= 1'b0;
      unal_q   <= 1'b0;
      mdata_q  <= '0;
      mvld_q   <= 1'b0;
      mlast_q  <= 1'b0;
      muser_q  <= 1'b0;
`ifdef RGBX_PACK_TKEEP_EN
      keep_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      res_q    <= res_d;
      flush8_q <= flush8_d;
      sof_q    <= sof_d;
      unal_q   <= unal_d;
      mdata_q  <= mdata_d;
      mvld_q   <= mvld_d;
      mlast_q  <= mlast_d;
      muser_q  <= muser_d;
`ifdef RGBX_PACK_TKEEP_EN
      keep_q   <= keep_d;
`endif
    end
  end

  assign O_s_tready  = s_rdy;
  assign O_m_tdata   = mdata_q;
  assign O_m_tvalid  = mvld_q;
  assign O_m_tlast   = mlast_q;
  assign O_m_tuser   = muser_q;
  assign O_unaligned = unal_q;
`ifdef RGBX_PACK_TKEEP_EN
  assign O_m_tkeep   = keep_q;
`endif

endmodule

// File: tb/tb_rgbx_pack_ctrl.sv
// tb_rgbx_pack_ctrl: directed vector table plus backpressure and reset
// sequences for rgbx_pack_ctrl (PAD_BYTE = 8'hEE).
module tb_rgbx_pack_ctrl;

  logic         clk;
  logic         rst_n;
  logic [127:0] s_data;
  logic         s_vld;
  logic         s_rdy;
  logic         s_last;
  logic         s_user;
  logic [127:0] m_data;
  logic         m_vld;
  logic         m_rdy;
  logic         m_last;
  logic         m_user;
  logic         unal;
`ifdef RGBX_PACK_TKEEP_EN
  logic [15:0]  m_keep;
`endif

  int n_cmp = 0;
  int n_err = 0;

  rgbx_pack_ctrl #(.PAD_BYTE(8'hEE)) dut (
    .I_clk      (clk),
    .I_rstn     (rst_n),
    .I_s_tdata  (s_data),
    .I_s_tvalid (s_vld),
    .O_s_tready (s_rdy),
    .I_s_tlast  (s_last),
    .I_s_tuser  (s_user),
    .O_m_tdata  (m_data),
    .O_m_tvalid (m_vld),
    .I_m_tready (m_rdy),
    .O_m_tlast  (m_last),
    .O_m_tuser  (m_user),
    .O_unaligned(unal)
`ifdef RGBX_PACK_TKEEP_EN
    ,
    .O_m_tkeep  (m_keep)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] din;
    logic         vld;
    logic         last;
    logic         user;
    logic         mrdy;
    logic         e_srdy;
    logic         e_mvld;
    logic [127:0] e_data;
    logic         e_last;
    logic         e_user;
    logic         e_unal;
    logic [15:0]  e_keep;
  } vec_t;

  vec_t tbl[9];

  // Input beat j: pixel n = 4j+w carries RGB bytes 3n, 3n+1, 3n+2.
  function automatic logic [127:0] beat(input int j);
    logic [127:0] r;
    int n;
    int b;
    r = '0;
    for (int w = 0; w < 4; w++) begin
      n = 4 * j + w;
      b = 3 * n;
      r[32*w +: 32] = {8'hAA, 8'(b + 2), 8'(b + 1), 8'(b)};
    end
    return r;
  endfunction

  // Output beat k of a dense stream: bytes 16k .. 16k+15.
  function automatic logic [127:0] seq(input int k);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = 8'(16 * k + i);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string nm);
    @(negedge clk);
    s_data = v.din;
    s_vld  = v.vld;
    s_last = v.last;
    s_user = v.user;
    m_rdy  = v.mrdy;
    #1;
    chk({nm, ".s_tready"}, 128'(s_rdy), 128'(v.e_srdy));
    @(posedge clk);
    #1;
    chk({nm, ".m_tvalid"}, 128'(m_vld), 128'(v.e_mvld));
    if (v.e_mvld) begin
      chk({nm, ".m_tdata"}, m_data, v.e_data);
      chk({nm, ".m_tlast"}, 128'(m_last), 128'(v.e_last));
      chk({nm, ".m_tuser"}, 128'(m_user), 128'(v.e_user));
`ifdef RGBX_PACK_TKEEP_EN
      chk({nm, ".m_tkeep"}, 128'(m_keep), 128'(v.e_keep));
`endif
    end
    chk({nm, ".unaligned"}, 128'(unal), 128'(v.e_unal));
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, ".m_tvalid"}, 128'(m_vld), 128'(0));
    chk({nm, ".m_tdata"}, m_data, 128'(0));
    chk({nm, ".m_tlast"}, 128'(m_last), 128'(0));
    chk({nm, ".m_tuser"}, 128'(m_user), 128'(0));
    chk({nm, ".unaligned"}, 128'(unal), 128'(0));
    chk({nm, ".s_tready"}, 128'(s_rdy), 128'(0));
`ifdef RGBX_PACK_TKEEP_EN
    chk({nm, ".m_tkeep"}, 128'(m_keep), 128'(0));
`endif
  endtask

  initial begin
    logic [127:0] s0;
    logic [127:0] s1;
    logic [127:0] fl8;
    logic [127:0] one;
    vec_t idle0;
    int j;
    int k;
    int cyc;
    logic hold;
    logic [127:0] held;
    logic s_hs;
    logic m_hs;

    s0  = seq(0);
    s1  = seq(1);
    fl8 = {64'hEEEE_EEEE_EEEE_EEEE, s1[63:0]};
    one = {32'hEEEE_EEEE, s0[95:0]};

    // din, vld, last, user, mrdy | srdy, mvld, data, last, user, unal, keep
    tbl[0] = '{beat(0), 1, 0, 1, 1, 1, 0, '0,     0, 0, 0, 16'h0000};
    tbl[1] = '{beat(1), 1, 0, 0, 1, 1, 1, seq(0), 0, 1, 0, 16'hFFFF};
    tbl[2] = '{beat(2), 1, 0, 0, 1, 1, 1, seq(1), 0, 0, 0, 16'hFFFF};
    tbl[3] = '{beat(3), 1, 1, 0, 1, 1, 1, seq(2), 1, 0, 0, 16'hFFFF};
    tbl[4] = '{beat(0), 1, 0, 0, 1, 1, 0, '0,     0, 0, 0, 16'h0000};
    tbl[5] = '{beat(1), 1, 1, 0, 1, 1, 1, seq(0), 0, 0, 0, 16'hFFFF};
    tbl[6] = '{'0,      0, 0, 0, 1, 0, 1, fl8,    1, 0, 1, 16'h00FF};
    tbl[7] = '{beat(0), 1, 1, 0, 1, 1, 1, one,    1, 0, 1, 16'h0FFF};
    tbl[8] = '{'0,      0, 0, 0, 1, 1, 0, '0,     0, 0, 1, 16'h0000};
    idle0  = '{'0,      0, 0, 0, 1, 1, 0, '0,     0, 0, 0, 16'h0000};

    rst_n  = 1'b0;
    s_data = '0;
    s_vld  = 1'b0;
    s_last = 1'b0;
    s_user = 1'b0;
    m_rdy  = 1'b0;
    #12;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Backpressure: 8-beat line, downstream ready toggling 1010...
    j    = 0;
    k    = 0;
    cyc  = 0;
    hold = 1'b0;
    held = '0;
    while (k < 6 && cyc < 100) begin
      @(negedge clk);
      m_rdy  = (cyc % 2 == 0);
      s_vld  = (j < 8);
      s_data = beat(j);
      s_last = (j == 7);
      s_user = 1'b0;
      #1;
      if (hold) chk("bp.stall_data", m_data, held);
      s_hs = s_vld && s_rdy;
      m_hs = m_vld && m_rdy;
      if (m_hs) begin
        chk($sformatf("bp.data%0d", k), m_data, seq(k));
        chk($sformatf("bp.last%0d", k), 128'(m_last), 128'(k == 5));
        k++;
      end
      hold = m_vld && !m_rdy;
      held = m_data;
      @(posedge clk);
      if (s_hs) j++;
      cyc++;
    end
    chk("bp.out_beats", 128'(k), 128'(6));
    chk("bp.in_beats", 128'(j), 128'(8));

    // Reset mid-line: two beats in, state S8 with an output beat held.
    @(negedge clk);
    s_vld  = 1'b1;
    s_data = beat(0);
    s_last = 1'b0;
    m_rdy  = 1'b1;
    @(negedge clk);
    s_data = beat(1);
    @(negedge clk);
    s_vld = 1'b0;
    m_rdy = 1'b0;
    #1;
    chk("mid.m_tvalid_held", 128'(m_vld), 128'(1));
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) apply(tbl[i], $sformatf("post%0d", i));
    apply(idle0, "post_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
